// File: rtl/peri_bus_arbiter.sv
// Two-master round-robin arbiter for the req/gnt/rvalid peripheral bus.
// An in-order ID FIFO routes each response back to the master that issued it.
module peri_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    s_req,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic                    s_write,
  output logic [DATA_WIDTH/8-1:0] s_be,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic                    s_gnt,
  input  logic                    s_rvalid,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  output logic                    busy_o,
  output logic                    err_rsp_o
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;

  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic          id_mem [MAX_OUTSTANDING];
  logic          rr_q;
  logic          lock_q;
  logic          lock_id_q;

  logic sel_id;
  logic sel_req;
  logic not_full;
  logic hs;
  logic fifo_pop;
  logic head_id;

  always_comb begin
    sel_id = 1'b0;
    if (lock_q)
      sel_id = lock_id_q;
    else if (m1_req && !m0_req)
      sel_id = 1'b1;
    else if (m0_req && m1_req)
      sel_id = rr_q;
  end

  assign sel_req  = sel_id ? m1_req : m0_req;
  assign not_full = count_q < CW'(MAX_OUTSTANDING);
  assign s_req    = sel_req && not_full;
  assign hs       = s_req && s_gnt;

  assign s_addr  = sel_id ? m1_addr  : m0_addr;
  assign s_write = sel_id ? m1_write : m0_write;
  assign s_be    = sel_id ? m1_be    : m0_be;
  assign s_wdata = sel_id ? m1_wdata : m0_wdata;

  assign m0_gnt = hs && !sel_id;
  assign m1_gnt = hs && sel_id;

  // Responses are in order, so the FIFO head names the owner of this response.
  assign fifo_pop  = s_rvalid && (count_q != '0);
  assign head_id   = id_mem[rd_ptr_q];
  assign m0_rvalid = fifo_pop && !head_id;
  assign m1_rvalid = fifo_pop && head_id;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign err_rsp_o = s_rvalid && (count_q == '0);
  assign busy_o    = (count_q != '0);

  // Control state: FIFO bookkeeping, round-robin pointer and request lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rr_q      <= 1'b0;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
    end else begin
      if (hs)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({hs, fifo_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (hs)
        rr_q <= ~sel_id;
      // Keep a stalled request pinned to its master so it stays stable until granted.
      if (hs) begin
        lock_q <= 1'b0;
      end else if (s_req) begin
        lock_q    <= 1'b1;
        lock_id_q <= sel_id;
      end else if (lock_q && !sel_req) begin
        lock_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs)
      id_mem[wr_ptr_q] <= sel_id;
  end

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Self-checking bench for peri_bus_arbiter: directed scenarios with literal
// expectations plus a randomized run against a queue-based reference model.
module tb_peri_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          m0_req, m1_req;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_write, m1_write;
  logic [DW/8-1:0] m0_be, m1_be;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_req, s_write, s_gnt, s_rvalid;
  logic [AW-1:0] s_addr;
  logic [DW/8-1:0] s_be;
  logic [DW-1:0] s_wdata, s_rdata;
  logic          busy_o, err_rsp_o;

  peri_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_write(s_write), .s_be(s_be), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
    .busy_o(busy_o), .err_rsp_o(err_rsp_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding owner IDs, favoured master, and the master
  // whose stalled request must be held (-1 when none).
  int q[$];
  int favour = 0;
  int held   = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit req_of(int m);
    return (m == 1) ? m1_req : m0_req;
  endfunction

  function automatic int model_sel();
    if (held >= 0) return held;
    if (m0_req && !m1_req) return 0;
    if (m1_req && !m0_req) return 1;
    if (m0_req && m1_req) return favour;
    return 0;
  endfunction

  task automatic check_cycle();
    int sel;
    bit sreq;
    int head;
    #3;
    sel  = model_sel();
    sreq = req_of(sel) && (q.size() < MO);
    head = (q.size() > 0) ? q[0] : -1;
    chk("s_req", s_req, sreq);
    chk("s_addr", s_addr, sel ? m1_addr : m0_addr);
    chk("s_write", s_write, sel ? m1_write : m0_write);
    chk("s_be", s_be, sel ? m1_be : m0_be);
    chk("s_wdata", s_wdata, sel ? m1_wdata : m0_wdata);
    chk("m0_gnt", m0_gnt, sreq && s_gnt && sel == 0);
    chk("m1_gnt", m1_gnt, sreq && s_gnt && sel == 1);
    chk("m0_rvalid", m0_rvalid, s_rvalid && head == 0);
    chk("m1_rvalid", m1_rvalid, s_rvalid && head == 1);
    chk("m0_rdata", m0_rdata, s_rdata);
    chk("m1_rdata", m1_rdata, s_rdata);
    chk("busy", busy_o, q.size() != 0);
    chk("err_rsp", err_rsp_o, s_rvalid && q.size() == 0);
  endtask

  task automatic advance();
    int sel;
    bit sreq, hs, pop;
    @(posedge clk);
    if (rst) begin
      q.delete();
      favour = 0;
      held   = -1;
    end else begin
      sel  = model_sel();
      sreq = req_of(sel) && (q.size() < MO);
      hs   = sreq && s_gnt;
      pop  = s_rvalid && (q.size() > 0);
      if (pop) void'(q.pop_front());
      if (hs) begin
        q.push_back(sel);
        favour = 1 - sel;
        held   = -1;
      end else if (sreq) begin
        held = sel;
      end else if (held >= 0 && !req_of(held)) begin
        held = -1;
      end
    end
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0; m0_addr = '0; m1_addr = '0;
    m0_write = 0; m1_write = 0; m0_be = '0; m1_be = '0;
    m0_wdata = '0; m1_wdata = '0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    check_cycle();
    advance();
    rst = 0;
  endtask

  initial begin
    idle();
    do_reset();

    // Reset state: everything quiet.
    check_cycle();
    chk("rst_busy", busy_o, 0);
    chk("rst_s_req", s_req, 0);
    advance();

    // Single m0 read with immediate grant and response one cycle later.
    m0_req = 1; m0_addr = 32'h1A10_0000; s_gnt = 1;
    check_cycle();
    chk("t1_gnt", m0_gnt, 1);
    chk("t1_busy0", busy_o, 0);
    advance();
    m0_req = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
    check_cycle();
    chk("t1_rvalid", m0_rvalid, 1);
    chk("t1_m1_rvalid", m1_rvalid, 0);
    chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("t1_busy1", busy_o, 1);
    advance();
    s_rvalid = 0;
    check_cycle();
    chk("t1_busy2", busy_o, 0);
    advance();

    // Both masters stream; grants and responses alternate.
    do_reset();
    m0_req = 1; m1_req = 1; s_gnt = 1;
    m0_addr = 32'h1000; m1_addr = 32'h2000;
    for (int i = 0; i < 6; i++) begin
      s_rvalid = (i > 0); s_rdata = i;
      check_cycle();
      chk("t2_gnt", {m1_gnt, m0_gnt}, (i % 2) ? 2'b10 : 2'b01);
      if (i > 0) chk("t2_rsp", {m1_rvalid, m0_rvalid}, ((i - 1) % 2) ? 2'b10 : 2'b01);
      advance();
    end

    // Stalled m1 request stays pinned while m0 joins.
    do_reset();
    m1_req = 1; m1_addr = 32'h1A10_0040;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin m0_req = 1; m0_addr = 32'h1A10_0080; end
      s_gnt = (i == 3);
      check_cycle();
      chk("t3_addr", s_addr, 32'h1A10_0040);
      chk("t3_m1_gnt", m1_gnt, i == 3);
      chk("t3_m0_gnt", m0_gnt, 0);
      advance();
    end
    m1_req = 0;
    check_cycle();
    chk("t3_m0_next", m0_gnt, 1);
    chk("t3_addr_m0", s_addr, 32'h1A10_0080);
    advance();

    // Full FIFO back-pressure: a freed slot is reusable only the next cycle.
    do_reset();
    m0_req = 1; s_gnt = 1; m0_addr = 32'h300;
    for (int i = 0; i < 5; i++) begin
      s_rvalid = (i == 3);
      check_cycle();
      chk("t4_s_req", s_req, (i < 2) || (i == 4));
      chk("t4_gnt", m0_gnt, (i < 2) || (i == 4));
      if (i == 3) chk("t4_rvalid", m0_rvalid, 1);
      advance();
    end

    // Reset with two outstanding, then a stray response and a fresh contest.
    idle();
    rst = 1;
    check_cycle();
    chk("t6_busy_pre", busy_o, 1);
    advance();
    rst = 0; s_rvalid = 1; s_rdata = 32'h55;
    check_cycle();
    chk("t6_busy", busy_o, 0);
    chk("t6_err", err_rsp_o, 1);
    chk("t6_rv", {m1_rvalid, m0_rvalid}, 2'b00);
    advance();
    s_rvalid = 0; m0_req = 1; m1_req = 1; s_gnt = 1;
    check_cycle();
    chk("t6_first", {m1_gnt, m0_gnt}, 2'b01);
    advance();

    // Unexpected response with an empty FIFO.
    do_reset();
    s_rvalid = 1; s_rdata = 32'h1234;
    check_cycle();
    chk("t5_err", err_rsp_o, 1);
    chk("t5_rv", {m1_rvalid, m0_rvalid}, 2'b00);
    advance();
    s_rvalid = 0;
    check_cycle();
    chk("t5_err_end", err_rsp_o, 0);
    advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst      = ($urandom % 250) == 0;
      m0_req   = ($urandom % 4) != 0;
      m1_req   = ($urandom % 3) != 0;
      m0_addr  = $urandom; m1_addr = $urandom;
      m0_write = $urandom; m1_write = $urandom;
      m0_be    = $urandom; m1_be = $urandom;
      m0_wdata = $urandom; m1_wdata = $urandom;
      s_gnt    = ($urandom % 3) != 0;
      s_rvalid = (q.size() > 0) ? (($urandom % 2) != 0) : (($urandom % 16) == 0);
      s_rdata  = $urandom;
      check_cycle();
      advance();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
